// File: rtl/ultrasonic_echo_responder_if.sv
// Ranging handshake bundle between an initiator (master) and the echo responder (slave).
interface ultrasonic_echo_responder_if #(
  parameter int CM_W = 9
);
  logic            trigger;
  logic [CM_W-1:0] distance_cm;
  logic            echo;
  logic            busy;
  logic            short_trig;

  modport master (output trigger, output distance_cm, input echo, input busy, input short_trig);
  modport slave  (input trigger, input distance_cm, output echo, output busy, output short_trig);
endinterface

// File: rtl/ultrasonic_echo_responder.sv
// Ultrasonic sensor stand-in: answers a trigger with an echo pulse whose width encodes distance_cm.
// Define ECHO_JITTER_EN to add 0-7 us of LFSR noise to each echo width.
//
// state     | meaning
// IDLE      | waiting for a synchronized trigger rise
// TRIG_HIGH | measuring trigger high time
// BURST     | modelled acoustic burst delay, busy high
// ECHO      | echo high for the latched width
// HOLDOFF   | dead time, triggers ignored
module ultrasonic_echo_responder #(
  parameter int CLKS_PER_US    = 100,
  parameter int MIN_TRIG_US    = 10,
  parameter int BURST_DELAY_US = 250,
  parameter int US_PER_CM      = 58,
  parameter int MAX_ECHO_US    = 38000,
  parameter int HOLDOFF_US     = 60000,
  parameter int CM_W           = 9
) (
  input  logic clk,
  input  logic rst,
  ultrasonic_echo_responder_if.slave bus
);

  localparam int TRIG_CLKS = MIN_TRIG_US * CLKS_PER_US;
  localparam int HW        = $clog2(TRIG_CLKS + 1);
  localparam int PW        = $clog2(CLKS_PER_US + 1);
  localparam int ECHO_TOP  = MAX_ECHO_US + 7;
  localparam int UMAX      = (ECHO_TOP > HOLDOFF_US)
                             ? ((ECHO_TOP > BURST_DELAY_US) ? ECHO_TOP : BURST_DELAY_US)
                             : ((HOLDOFF_US > BURST_DELAY_US) ? HOLDOFF_US : BURST_DELAY_US);
  localparam int UW        = $clog2(UMAX + 1);

  typedef enum logic [2:0] {IDLE, TRIG_HIGH, BURST, ECHO, HOLDOFF} state_t;

  state_t          state, state_nxt;
  logic            trig_s1, trig_s2, trig_d;
  logic            rise, fall;
  logic [HW-1:0]   hi_cnt;
  logic [PW-1:0]   presc;
  logic [UW-1:0]   us_left, width_us, load_us;
  logic [31:0]     prod;
  logic [UW-1:0]   w_clamp, w_full;
  logic            phase_done, accept, short_nxt, short_q, echo_c, busy_c;

  assign rise       = trig_s2 & ~trig_d;
  assign fall       = ~trig_s2 & trig_d;
  assign phase_done = (presc == '0) && (us_left == '0);

  // Product kept at 32 bits so large distances clamp instead of wrapping.
  assign prod    = 32'(bus.distance_cm) * 32'(US_PER_CM);
  assign w_clamp = ((bus.distance_cm == '0) || (prod > 32'(MAX_ECHO_US)))
                   ? UW'(MAX_ECHO_US) : prod[UW-1:0];

`ifdef ECHO_JITTER_EN
  logic [15:0] lfsr;
  assign w_full = w_clamp + UW'(lfsr[2:0]);

  always_ff @(posedge clk or posedge rst) begin
    if (rst)         lfsr <= 16'hACE1;
    else if (accept) lfsr <= {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
  end
`else
  assign w_full = w_clamp;
`endif

  always_comb begin
    state_nxt = state;
    accept    = 1'b0;
    short_nxt = 1'b0;
    echo_c    = 1'b0;
    busy_c    = 1'b0;
    case (state)
      IDLE:      if (rise) state_nxt = TRIG_HIGH;
      TRIG_HIGH: if (fall) begin
                   if (hi_cnt == HW'(TRIG_CLKS)) begin
                     accept    = 1'b1;
                     state_nxt = BURST;
                   end else begin
                     short_nxt = 1'b1;
                     state_nxt = IDLE;
                   end
                 end
      BURST:     begin busy_c = 1'b1; if (phase_done) state_nxt = ECHO; end
      ECHO:      begin busy_c = 1'b1; echo_c = 1'b1; if (phase_done) state_nxt = HOLDOFF; end
      HOLDOFF:   begin busy_c = 1'b1; if (phase_done) state_nxt = IDLE; end
      default:   state_nxt = IDLE;
    endcase
  end

  always_comb begin
    load_us = '0;
    case (state_nxt)
      BURST:   load_us = UW'(BURST_DELAY_US - 1);
      ECHO:    load_us = width_us - UW'(1);
      HOLDOFF: load_us = UW'(HOLDOFF_US - 1);
      default: load_us = '0;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      trig_s1  <= 1'b0;
      trig_s2  <= 1'b0;
      trig_d   <= 1'b0;
      state    <= IDLE;
      short_q  <= 1'b0;
      hi_cnt   <= '0;
      width_us <= '0;
      presc    <= '0;
      us_left  <= '0;
    end else begin
      trig_s1 <= bus.trigger;
      trig_s2 <= trig_s1;
      trig_d  <= trig_s2;
      state   <= state_nxt;
      short_q <= short_nxt;
      // The rise-detect cycle already saw trigger high, so it counts as the first clock.
      if (state == IDLE && rise)
        hi_cnt <= HW'(1);
      else if (state == TRIG_HIGH && trig_s2 && hi_cnt != HW'(TRIG_CLKS))
        hi_cnt <= hi_cnt + HW'(1);
      if (accept) width_us <= w_full;
      if (state_nxt != state) begin
        presc   <= PW'(CLKS_PER_US - 1);
        us_left <= load_us;
      end else if (presc == '0) begin
        presc <= PW'(CLKS_PER_US - 1);
        if (us_left != '0) us_left <= us_left - UW'(1);
      end else begin
        presc <= presc - PW'(1);
      end
    end
  end

  assign bus.echo       = echo_c;
  assign bus.busy       = busy_c;
  assign bus.short_trig = short_q;

endmodule

// File: tb/tb_ultrasonic_echo_responder.sv
// Directed bench for ultrasonic_echo_responder with scaled-down timing parameters.
module tb_ultrasonic_echo_responder;
  localparam int CPU    = 4;
  localparam int MIN_US = 3;
  localparam int BD_US  = 5;
  localparam int UPC    = 3;
  localparam int MAX_US = 40;
  localparam int HO_US  = 10;
  localparam int CMW    = 9;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  ultrasonic_echo_responder_if #(.CM_W(CMW)) bus ();

  ultrasonic_echo_responder #(
    .CLKS_PER_US(CPU), .MIN_TRIG_US(MIN_US), .BURST_DELAY_US(BD_US), .US_PER_CM(UPC),
    .MAX_ECHO_US(MAX_US), .HOLDOFF_US(HO_US), .CM_W(CMW)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  int n_vec = 0;
  int n_err = 0;

  // Phase-length monitor sampled on the falling edge.
  int c_burst = 0, c_echo = 0, c_hold = 0;
  int m_burst = 0, m_echo = 0, m_hold = 0;
  int n_done = 0, n_rise = 0, n_echo = 0, n_short = 0;
  bit prev_busy = 0, prev_echo = 0, echo_seen = 0;

  always @(negedge clk) begin
    prev_busy <= bus.busy;
    prev_echo <= bus.echo;
    if (bus.short_trig) n_short <= n_short + 1;
    if (bus.echo && !prev_echo) n_echo <= n_echo + 1;
    if (bus.busy && !prev_busy) begin
      n_rise <= n_rise + 1;
      c_burst <= 1; c_echo <= 0; c_hold <= 0; echo_seen <= 0;
    end else if (bus.busy) begin
      if (bus.echo) begin
        c_echo <= c_echo + 1;
        echo_seen <= 1;
      end else if (echo_seen) c_hold <= c_hold + 1;
      else c_burst <= c_burst + 1;
    end
    if (!bus.busy && prev_busy) begin
      m_burst <= c_burst; m_echo <= c_echo; m_hold <= c_hold;
      n_done <= n_done + 1;
    end
  end

  logic [15:0] model = 16'hACE1;
  int jit = 0;

  task automatic chk(input string tag, input int obs, input int exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
    #1;
  endtask

  task automatic pulse(input int n);
    @(posedge clk);
    #1 bus.trigger = 1'b1;
    repeat (n) @(posedge clk);
    #1 bus.trigger = 1'b0;
  endtask

  function automatic int w_us(input int d);
    return (d == 0 || d * UPC > MAX_US) ? MAX_US : d * UPC;
  endfunction

  task automatic acc();
`ifdef ECHO_JITTER_EN
    jit = int'(model[2:0]);
    model = {model[14:0], model[15] ^ model[13] ^ model[12] ^ model[10]};
`else
    jit = 0;
`endif
  endtask

  task automatic wait_done(input int base, input string tag);
    for (int k = 0; k < 400 && n_done == base; k++) cyc(1);
    chk({tag, "_done"}, n_done - base, 1);
  endtask

  task automatic run_full(input int d, input int hi, input string tag);
    int base, lat;
    bus.distance_cm = CMW'(d);
    base = n_done;
    pulse(hi);
    acc();
    lat = 0;
    @(negedge clk);
    while (!bus.busy && lat < 20) begin
      lat++;
      @(negedge clk);
    end
    chk({tag, "_lat"}, lat, 3);
    wait_done(base, tag);
    chk({tag, "_burst"}, m_burst, BD_US * CPU);
    chk({tag, "_echo"}, m_echo, (w_us(d) + jit) * CPU);
    chk({tag, "_hold"}, m_hold, HO_US * CPU);
  endtask

  initial begin
    int bs, br, be;
    bus.trigger = 1'b0;
    bus.distance_cm = CMW'(10);
    cyc(3);
    chk("rst_echo", int'(bus.echo), 0);
    chk("rst_busy", int'(bus.busy), 0);
    chk("rst_short", int'(bus.short_trig), 0);
    rst = 1'b0;
    cyc(3);

    run_full(10, 12, "d10");

    bs = n_short; br = n_rise; be = n_echo;
    pulse(11);
    cyc(30);
    chk("short_pulses", n_short - bs, 1);
    chk("short_busy", n_rise - br, 0);
    chk("short_echo", n_echo - be, 0);
    run_full(10, 12, "after_short");

    run_full(0, 12, "d0");
    run_full(171, 12, "d171");
    run_full(13, 12, "d13");
    run_full(14, 12, "d14");
    run_full(10, 40, "stuck_high");

    bus.distance_cm = CMW'(10);
    bs = n_short; br = n_rise; be = n_echo;
    pulse(12);
    acc();
    for (int k = 0; k < 50 && !bus.busy; k++) cyc(1);
    cyc(5);
    bus.distance_cm = CMW'(200);
    for (int k = 0; k < 100 && !bus.echo; k++) cyc(1);
    cyc(10);
    pulse(12);
    for (int k = 0; k < 300 && bus.echo; k++) cyc(1);
    cyc(2);
    bus.trigger = 1'b1;
    wait_done(br == n_rise ? n_done : n_done, "inflight");
    cyc(20);
    bus.trigger = 1'b0;
    cyc(40);
    chk("inflight_echo", m_echo, (w_us(10) + jit) * CPU);
    chk("inflight_pulses", n_echo - be, 1);
    chk("inflight_accepts", n_rise - br, 1);
    chk("inflight_short", n_short - bs, 0);

    bus.distance_cm = CMW'(10);
    pulse(12);
    acc();
    for (int k = 0; k < 100 && !bus.echo; k++) cyc(1);
    cyc(10);
    #2 rst = 1'b1;
    #1;
    chk("rst_mid_echo", int'(bus.echo), 0);
    chk("rst_mid_busy", int'(bus.busy), 0);
    model = 16'hACE1;
    cyc(3);
    rst = 1'b0;
    cyc(3);
    run_full(10, 12, "post_rst");

    run_full(10, 12, "seq1");
    run_full(10, 12, "seq2");
    run_full(10, 12, "seq3");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
